// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side word port of the load/store unit.
// The master modport drives requests and memory read data; the slave modport is the unit itself.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: loads 2 cycles, SW 2 cycles, SB/SH read-modify-write 3 cycles, rejects 1 cycle.
// One request in flight, requests ignored outside IDLE; no response backpressure. Macro LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int MEM_WORDS = 2048
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  if (MEM_WORDS < 1) begin : g_cfg_check
    $error("load_store_unit: MEM_WORDS must be at least 1");
  end

  state_t      state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic [1:0]  acc_lane;
  logic        acc_bad;

  always_comb begin
    acc_lane = bus.req_addr[1:0];
    acc_bad  = (bus.req_funct3 inside {3'b011, 3'b110, 3'b111}) ||
               (bus.req_we && bus.req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])         acc_bad = 1'b1;
    if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) acc_bad = 1'b1;
`else
    if (bus.req_funct3[1:0] == 2'b01) acc_lane[0] = 1'b0;
    if (bus.req_funct3[1:0] == 2'b10) acc_lane    = 2'b00;
`endif
  end

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [31:0] sh;
    sh = w >> {lane, 3'b000};
    case (f3)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_ext = {24'h0, sh[7:0]};
      3'b101:  load_ext = {16'h0, sh[15:0]};
      default: load_ext = w;
    endcase
  endfunction

  // Replicate the store data across lanes so the shifted mask alone picks the target lane.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic half, input logic [1:0] lane);
    logic [31:0] mask;
    logic [31:0] data;
    mask  = (half ? 32'h0000_FFFF : 32'h0000_00FF) << {lane, 3'b000};
    data  = half ? {2{wd[15:0]}} : {4{wd[7:0]}};
    merge = (old & ~mask) | (data & mask);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      lane_q       <= 2'b00;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_we_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            f3_q        <= bus.req_funct3;
            lane_q      <= acc_lane;
            mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
            mem_wdata_q <= bus.req_wdata;
            req_ready_q <= 1'b0;
            if (acc_bad) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (bus.req_we && bus.req_funct3[1:0] == 2'b10) begin
              state_q  <= WRITE;
              mem_we_q <= 1'b1;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (we_q) begin
            mem_wdata_q <= merge(bus.mem_rdata, mem_wdata_q, f3_q[0], lane_q);
            mem_we_q    <= 1'b1;
            state_q     <= WRITE;
          end else begin
            resp_rdata_q <= load_ext(bus.mem_rdata, f3_q, lane_q);
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        WRITE: begin
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  // Gate with rst so a write in flight is cut off in the very cycle reset rises.
  assign bus.mem_we     = mem_we_q & ~rst;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a reference model predicts data, error and latency per accepted request.
// Expectations for misaligned accesses follow LSU_MISALIGN_TRAP_EN when the bench is built with it.
module tb_load_store_unit;
  localparam int MEM_WORDS = 2048;
  localparam int IW = $clog2(MEM_WORDS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  assign bus.mem_rdata = mem[bus.mem_addr[IW+1:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[IW+1:2]] <= bus.mem_wdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          we_cnt  = 0;
  logic [31:0] last_waddr = 32'h0;
  logic [31:0] last_wdata = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_we) begin
      we_cnt++;
      last_waddr = bus.mem_addr;
      last_wdata = bus.mem_wdata;
    end
    if (bus.resp_valid) begin
      chk("resp_has_pending_req", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", 32'(bus.resp_err), 32'(e.err));
        chk("resp_latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rd,
                                output logic err, output int lat);
    logic [IW-1:0] idx;
    logic [31:0]   w;
    int            b;
    idx = addr[IW+1:2];
    b   = int'(addr[1:0]);
    w   = ref_mem[idx];
    err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3[1:0] == 2'b01 && (b % 2) == 1) || (f3[1:0] == 2'b10 && b != 0)) err = 1'b1;
`else
    if (f3[1:0] == 2'b01) b = b - (b % 2);
    if (f3[1:0] == 2'b10) b = 0;
`endif
    rd  = 32'h0;
    lat = 1;
    if (!err) begin
      if (!we) begin
        lat = 2;
        case (f3)
          3'b000:  rd = {{24{w[b*8+7]}}, w[b*8 +: 8]};
          3'b001:  rd = {{16{w[b*8+15]}}, w[b*8 +: 16]};
          3'b010:  rd = w;
          3'b100:  rd = {24'h0, w[b*8 +: 8]};
          3'b101:  rd = {16'h0, w[b*8 +: 16]};
          default: rd = 32'h0;
        endcase
      end else begin
        case (f3)
          3'b000:  begin w[b*8 +: 8]  = wdata[7:0];  lat = 3; end
          3'b001:  begin w[b*8 +: 16] = wdata[15:0]; lat = 3; end
          default: begin w = wdata; lat = 2; end
        endcase
        ref_mem[idx] = w;
      end
    end
  endfunction

  task automatic poke(input logic [31:0] addr, input logic [31:0] val);
    mem[addr[IW+1:2]]     <= val;
    ref_mem[addr[IW+1:2]] = val;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  task automatic push_expect(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata);
    exp_t e;
    int   lat;
    model(we, f3, addr, wdata, e.rdata, e.err, lat);
    e.due = cyc + lat;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    chk("drain_pending", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    @(negedge clk);
    drive(we, f3, addr, wdata);
    for (int k = 0; k < 20 && !bus.req_ready; k++) @(negedge clk);
    chk("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
    push_expect(we, f3, addr, wdata);
    @(negedge clk);
    bus.req_valid = 1'b0;
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int accepts;
    logic saw_we;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i]     <= 32'h0;
      ref_mem[i] = 32'h0;
    end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    rst = 1'b0;

    // Byte loads, signed and unsigned.
    poke(32'h40, 32'h8899AABB);
    issue(1'b0, 3'b000, 32'h41, 32'h0);
    issue(1'b0, 3'b100, 32'h41, 32'h0);

    // Halfword store as read-modify-write, then read back.
    poke(32'h40, 32'h11223344);
    w0 = we_cnt;
    issue(1'b1, 3'b001, 32'h42, 32'h0000BEEF);
    chk("sh_we_cycles", 32'(we_cnt - w0), 32'd1);
    chk("sh_mem_wdata", last_wdata, 32'hBEEF3344);
    chk("sh_mem_addr", last_waddr, 32'h40);
    issue(1'b0, 3'b010, 32'h40, 32'h0);

    w0 = we_cnt;
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    chk("sw_we_cycles", 32'(we_cnt - w0), 32'd1);
    chk("sw_mem_addr", last_waddr, 32'h100);
    chk("sw_mem_wdata", last_wdata, 32'hDEADBEEF);

    w0 = we_cnt;
    issue(1'b0, 3'b010, 32'h102, 32'h0);
    chk("misaligned_lw_no_write", 32'(we_cnt - w0), 32'd0);

    // Illegal funct3 codes never touch memory.
    w0 = we_cnt;
    issue(1'b0, 3'b011, 32'h40, 32'h0);
    issue(1'b0, 3'b111, 32'h40, 32'h0);
    issue(1'b1, 3'b100, 32'h44, 32'h12345678);
    chk("illegal_no_write", 32'(we_cnt - w0), 32'd0);

    issue(1'b0, 3'b001, 32'h42, 32'h0);
    issue(1'b0, 3'b101, 32'h42, 32'h0);
    issue(1'b0, 3'b001, 32'h43, 32'h0);
    issue(1'b1, 3'b000, 32'h43, 32'hFFFFFF5A);
    issue(1'b1, 3'b000, 32'h40, 32'h00000071);
    issue(1'b0, 3'b010, 32'h40, 32'h0);

    // Reset during the write cycle of a byte store aborts it cleanly.
    poke(32'h200, 32'h01020304);
    @(negedge clk);
    drive(1'b1, 3'b000, 32'h201, 32'h000000FF);
    @(negedge clk);
    bus.req_valid = 1'b0;
    saw_we = 1'b0;
    for (int k = 0; k < 10 && !saw_we; k++) begin
      @(negedge clk);
      saw_we = bus.mem_we;
    end
    chk("abort_reached_write", 32'(saw_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_mem_we_drop", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_word_unchanged", mem[10'h80], 32'h01020304);
    repeat (4) @(negedge clk);

    // Back-to-back loads with req_valid held for six cycles.
    for (int i = 0; i < 6; i++) poke(32'h300 + 32'(4 * i), 32'hA0000000 + 32'(i));
    @(negedge clk);
    accepts = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 3'b010, 32'h300 + 32'(4 * i), 32'h0);
      if (bus.req_ready) begin
        push_expect(1'b0, 3'b010, 32'h300 + 32'(4 * i), 32'h0);
        accepts++;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    drain();
    chk("b2b_accept_count", 32'(accepts), 32'd2);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
